interrupt_dispatcher: RTL and testbench
=======================================

Name: interrupt_dispatcher

Overview:
Processor-side counterpart of the interrupt request controller. It consumes the per-source pending flags (interrupt_flag_1..3) and offers each pending source to one of two processors. It tracks acknowledge and return-from-interrupt from each processor. It drives interrupt_handling_x while a source is in service, and pulses RETI_x to pop that source's request buffer.

Parameters:
ACK_TIMEOUT, 16, cycles an offer may wait for cpuN_irq_ack before it is withdrawn (>=2); counter width is clog2(ACK_TIMEOUT+1).
ROUND_ROBIN, 0, 0 = fixed priority (source 1 highest); 1 = rotating priority.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
interrupt_flag_1/2/3  in  1 each  source pending (level)
interrupt_handling_1/2/3  out  1 each  source currently in service
RETI_1/2/3  out  1 each  one-cycle pop pulse to the source request buffer
cpu0_available, cpu1_available  in  1 each  processor may accept an interrupt
cpu0_irq_valid, cpu1_irq_valid  out  1 each  offer to the processor
cpu0_irq_id, cpu1_irq_id  out  2 each  offered source (1..3; 0 when idle)
cpu0_irq_ack, cpu1_irq_ack  in  1 each  processor accepts the offer
cpu0_reti, cpu1_reti  in  1 each  processor finished its ISR (pulse)

Behaviour:
- Reset (async, rst_n=0): all outputs 0; both FSMs IDLE; timeout counters 0; busy/guard bits 0; RR pointer = source 1. Reset mid-service drops the service silently: no RETI pulse.
- Eligibility of source x: flag_x & ~busy_x & ~guard_x.
  - busy_x is set while any FSM holds x in OFFER, SERVICE or RELEASE.
  - A source is never held by both CPUs.
- Per-CPU FSM, states IDLE, OFFER, SERVICE, RELEASE:
  - IDLE -> OFFER: when available=1 and an eligible source exists. The selected id is registered; irq_valid=1 from the next cycle.
    - CPU0 selects first.
    - CPU1 selects in the same cycle from the remaining eligible sources, excluding CPU0's pick.
  - OFFER: irq_valid=1 and irq_id held stable.
    - ack=1 -> SERVICE.
    - Otherwise, flag_x=0 (source disabled) -> IDLE, no RETI.
    - Otherwise, counter reaches ACK_TIMEOUT -> IDLE, no RETI. The source becomes eligible again.
    - ack beats timeout and flag drop in the same cycle.
  - SERVICE: irq_valid=0; interrupt_handling_x=1. reti=1 -> RELEASE.
  - RELEASE: exactly one cycle. RETI_x=1, interrupt_handling_x=0, guard_x set. -> IDLE.
    - guard_x stays set for the RELEASE cycle plus one cycle, so the request buffer empty flag can settle before redispatch.
- Ignored inputs: ack outside OFFER; reti outside SERVICE; available is sampled only in IDLE.
- Priority:
  - ROUND_ROBIN=0: lowest index eligible wins.
  - ROUND_ROBIN=1: search starts at pointer. On each accepted ack, the pointer moves to the acked source+1 (wrapping 3->1). If both CPUs ack in the same cycle, CPU1's id updates the pointer.
- Latencies (from the triggering edge):
  - flag->irq_valid: 1 cycle.
  - ack->interrupt_handling: 1 cycle.
  - reti->RETI pulse: 1 cycle.
  - Earliest redispatch of the same source: 2 cycles after RETI.
- Simultaneous events:
  - Both CPUs fire reti in the same cycle for different sources: both RETI pulses are issued in the same cycle.
  - Each RETI_x is driven by at most one FSM (guaranteed by busy).

Test Plan:
- Reset, then flag_2=1, both CPUs available -> cpu0_irq_valid=1, id=2 at cycle 1; cpu1 idle. cpu0_irq_ack at cycle 3 -> interrupt_handling_2=1 at cycle 4. cpu0_reti at cycle 10 -> RETI_2=1 at cycle 11 only; handling_2=0 at cycle 11.
- flags 1,2,3 all high, both CPUs available, ROUND_ROBIN=0 -> cpu0 offered id 1, cpu1 offered id 2 in the same cycle; source 3 waits until one CPU returns to IDLE.
- Offer with no ack, ACK_TIMEOUT=16 -> irq_valid high for exactly 16 cycles, then 0. The source is re-offered the next eligible cycle; no RETI pulse occurs.
- flag_1 stays high after RETI_1 (more queued requests) -> source 1 is re-offered no earlier than 2 cycles after the RETI_1 pulse; RETI_1 pulses once per service.
- ROUND_ROBIN=1, flags 1 and 3 held high, only cpu0 available; ack and reti each service -> offered id sequence 1,3,1,3.
- rst_n dropped during SERVICE -> all outputs 0 asynchronously, no RETI pulse; after release the source is offered afresh if its flag is still high.

Source files
------------

// File: rtl/interrupt_dispatcher.sv
// Offers pending interrupt sources to two CPUs and tracks ack/reti per source.
// Latency: flag->offer 1 cycle, ack->handling 1 cycle, reti->RETI 1 cycle; same source redispatchable 2 cycles after RETI.
// Backpressure: a CPU is offered work only while available in IDLE; an unacked offer is withdrawn after ACK_TIMEOUT cycles.
module interrupt_dispatcher #(
   parameter int ACK_TIMEOUT = 16,
   parameter int ROUND_ROBIN = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       interrupt_flag_1,
   input  logic       interrupt_flag_2,
   input  logic       interrupt_flag_3,
   output logic       interrupt_handling_1,
   output logic       interrupt_handling_2,
   output logic       interrupt_handling_3,
   output logic       RETI_1,
   output logic       RETI_2,
   output logic       RETI_3,
   input  logic       cpu0_available,
   input  logic       cpu1_available,
   output logic       cpu0_irq_valid,
   output logic       cpu1_irq_valid,
   output logic [1:0] cpu0_irq_id,
   output logic [1:0] cpu1_irq_id,
   input  logic       cpu0_irq_ack,
   input  logic       cpu1_irq_ack,
   input  logic       cpu0_reti,
   input  logic       cpu1_reti
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_OFFER   = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]    state_q [2];
   logic [1:0]    id_q    [2];
   logic [CW-1:0] cnt_q   [2];
   logic [3:1]    guard_q;
   logic [1:0]    ptr_q;

   logic [3:1] flag;
   logic [3:1] busy;
   logic [3:1] rel_now;
   logic [3:1] in_service;
   logic [3:1] elig;
   logic [3:1] elig_cpu1;
   logic [1:0] avail;
   logic [1:0] ack;
   logic [1:0] reti;
   logic [1:0] take;
   logic [1:0] acked;
   logic [1:0] src_flag;
   logic [1:0] pick_id [2];
   logic [1:0] start;

   assign flag  = {interrupt_flag_3, interrupt_flag_2, interrupt_flag_1};
   assign avail = {cpu1_available, cpu0_available};
   assign ack   = {cpu1_irq_ack, cpu0_irq_ack};
   assign reti  = {cpu1_reti, cpu0_reti};

   function automatic logic [1:0] next_src(input logic [1:0] s);
      return (s == 2'd3) ? 2'd1 : s + 2'd1;
   endfunction

   // First candidate in circular order beginning at start; 0 if none.
   function automatic logic [1:0] pick_src(input logic [3:1] cand, input logic [1:0] first);
      logic [1:0] s;
      logic [1:0] found;
      found = 2'd0;
      s     = first;
      for (int k = 0; k < 3; k++) begin
         if (found == 2'd0 && cand[s]) found = s;
         s = next_src(s);
      end
      return found;
   endfunction

   always_comb begin
      busy       = '0;
      rel_now    = '0;
      in_service = '0;
      src_flag   = '0;
      for (int c = 0; c < 2; c++) begin
         for (int x = 1; x <= 3; x++) begin
            if (id_q[c] == 2'(x)) begin
               if (state_q[c] != S_IDLE)    busy[x]       = 1'b1;
               if (state_q[c] == S_SERVICE) in_service[x] = 1'b1;
               if (state_q[c] == S_RELEASE) rel_now[x]    = 1'b1;
               if (flag[x])                 src_flag[c]   = 1'b1;
            end
         end
      end
   end

   // The guard covers the RELEASE cycle and the one after, letting the source's empty flag settle.
   assign elig  = flag & ~busy & ~(rel_now | guard_q);
   assign start = (ROUND_ROBIN != 0) ? ptr_q : 2'd1;

   always_comb begin
      pick_id[0] = pick_src(elig, start);
      take[0]    = (state_q[0] == S_IDLE) && avail[0] && (pick_id[0] != 2'd0);
      elig_cpu1  = elig;
      for (int x = 1; x <= 3; x++) begin
         if (take[0] && pick_id[0] == 2'(x)) elig_cpu1[x] = 1'b0;
      end
      pick_id[1] = pick_src(elig_cpu1, start);
      take[1]    = (state_q[1] == S_IDLE) && avail[1] && (pick_id[1] != 2'd0);
      acked[0]   = (state_q[0] == S_OFFER) && ack[0];
      acked[1]   = (state_q[1] == S_OFFER) && ack[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            state_q[c] <= S_IDLE;
            id_q[c]    <= 2'd0;
            cnt_q[c]   <= '0;
         end
         guard_q <= '0;
         ptr_q   <= 2'd1;
      end else begin
         guard_q <= rel_now;
         if (acked[1])      ptr_q <= next_src(id_q[1]);
         else if (acked[0]) ptr_q <= next_src(id_q[0]);
         for (int c = 0; c < 2; c++) begin
            case (state_q[c])
               S_IDLE: begin
                  if (take[c]) begin
                     state_q[c] <= S_OFFER;
                     id_q[c]    <= pick_id[c];
                     cnt_q[c]   <= '0;
                  end
               end
               S_OFFER: begin
                  if (ack[c]) begin
                     state_q[c] <= S_SERVICE;
                  end else if (!src_flag[c] || cnt_q[c] == CNT_LAST) begin
                     state_q[c] <= S_IDLE;
                     id_q[c]    <= 2'd0;
                  end else begin
                     cnt_q[c] <= cnt_q[c] + 1'b1;
                  end
               end
               S_SERVICE: begin
                  if (reti[c]) state_q[c] <= S_RELEASE;
               end
               default: begin
                  state_q[c] <= S_IDLE;
                  id_q[c]    <= 2'd0;
               end
            endcase
         end
      end
   end

   assign cpu0_irq_valid = (state_q[0] == S_OFFER);
   assign cpu1_irq_valid = (state_q[1] == S_OFFER);
   assign cpu0_irq_id    = cpu0_irq_valid ? id_q[0] : 2'd0;
   assign cpu1_irq_id    = cpu1_irq_valid ? id_q[1] : 2'd0;

   assign interrupt_handling_1 = in_service[1];
   assign interrupt_handling_2 = in_service[2];
   assign interrupt_handling_3 = in_service[3];
   assign RETI_1 = rel_now[1];
   assign RETI_2 = rel_now[2];
   assign RETI_3 = rel_now[3];

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Bench for interrupt_dispatcher: fixed-priority (dut_a) and rotating-priority (dut_b) copies share stimulus.
module tb_interrupt_dispatcher;

   localparam int ACK_T     = 16;
   localparam int M_IDLE    = 0;
   localparam int M_OFFER   = 1;
   localparam int M_SERVICE = 2;
   localparam int M_RELEASE = 3;

   logic       clk;
   logic       rst_n;
   logic [3:1] flag;
   logic [1:0] avail;
   logic [1:0] ack;
   logic [1:0] reti;

   wire       v0a, v1a, v0b, v1b;
   wire [1:0] id0a, id1a, id0b, id1b;
   wire [3:1] hnda, rta, hndb, rtb;

   int checks;
   int failures;

   // Reference model: per instance g, per cpu c: what it holds and in which phase.
   int m_ph  [2][2];
   int m_src [2][2];
   int m_age [2][2];
   int m_rel [2][4];
   int m_ptr [2];
   int m_cyc;

   interrupt_dispatcher #(.ACK_TIMEOUT(ACK_T), .ROUND_ROBIN(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .interrupt_flag_1(flag[1]), .interrupt_flag_2(flag[2]), .interrupt_flag_3(flag[3]),
      .interrupt_handling_1(hnda[1]), .interrupt_handling_2(hnda[2]), .interrupt_handling_3(hnda[3]),
      .RETI_1(rta[1]), .RETI_2(rta[2]), .RETI_3(rta[3]),
      .cpu0_available(avail[0]), .cpu1_available(avail[1]),
      .cpu0_irq_valid(v0a), .cpu1_irq_valid(v1a),
      .cpu0_irq_id(id0a), .cpu1_irq_id(id1a),
      .cpu0_irq_ack(ack[0]), .cpu1_irq_ack(ack[1]),
      .cpu0_reti(reti[0]), .cpu1_reti(reti[1])
   );

   interrupt_dispatcher #(.ACK_TIMEOUT(ACK_T), .ROUND_ROBIN(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .interrupt_flag_1(flag[1]), .interrupt_flag_2(flag[2]), .interrupt_flag_3(flag[3]),
      .interrupt_handling_1(hndb[1]), .interrupt_handling_2(hndb[2]), .interrupt_handling_3(hndb[3]),
      .RETI_1(rtb[1]), .RETI_2(rtb[2]), .RETI_3(rtb[3]),
      .cpu0_available(avail[0]), .cpu1_available(avail[1]),
      .cpu0_irq_valid(v0b), .cpu1_irq_valid(v1b),
      .cpu0_irq_id(id0b), .cpu1_irq_id(id1b),
      .cpu0_irq_ack(ack[0]), .cpu1_irq_ack(ack[1]),
      .cpu0_reti(reti[0]), .cpu1_reti(reti[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int g = 0; g < 2; g++) begin
         for (int c = 0; c < 2; c++) begin
            m_ph[g][c]  = M_IDLE;
            m_src[g][c] = 0;
            m_age[g][c] = 0;
         end
         for (int x = 0; x < 4; x++) m_rel[g][x] = -10;
         m_ptr[g] = 1;
      end
      m_cyc = 0;
   endtask

   task automatic model_advance();
      for (int g = 0; g < 2; g++) begin
         bit free_src [4];
         int pick [2];
         int first;
         int s;
         free_src[0] = 1'b0;
         for (int x = 1; x <= 3; x++) begin
            free_src[x] = flag[x] && (m_cyc - m_rel[g][x] >= 2);
            for (int c = 0; c < 2; c++)
               if (m_ph[g][c] != M_IDLE && m_src[g][c] == x) free_src[x] = 1'b0;
         end
         first = (g == 1) ? m_ptr[g] : 1;
         for (int c = 0; c < 2; c++) begin
            pick[c] = 0;
            if (m_ph[g][c] == M_IDLE && avail[c]) begin
               for (int k = 0; k < 3; k++) begin
                  s = (first - 1 + k) % 3 + 1;
                  if (pick[c] == 0 && free_src[s]) pick[c] = s;
               end
            end
            if (pick[c] != 0) free_src[pick[c]] = 1'b0;
         end
         for (int c = 0; c < 2; c++) begin
            case (m_ph[g][c])
               M_IDLE: if (pick[c] != 0) begin
                  m_ph[g][c] = M_OFFER; m_src[g][c] = pick[c]; m_age[g][c] = 0;
               end
               M_OFFER: begin
                  if (ack[c]) begin
                     m_ph[g][c] = M_SERVICE;
                     m_ptr[g] = m_src[g][c] % 3 + 1;
                  end else if (!flag[m_src[g][c]] || m_age[g][c] + 1 == ACK_T) begin
                     m_ph[g][c] = M_IDLE; m_src[g][c] = 0;
                  end else begin
                     m_age[g][c]++;
                  end
               end
               M_SERVICE: if (reti[c]) m_ph[g][c] = M_RELEASE;
               default: begin
                  m_rel[g][m_src[g][c]] = m_cyc;
                  m_ph[g][c] = M_IDLE; m_src[g][c] = 0;
               end
            endcase
         end
      end
      m_cyc++;
   endtask

   function automatic logic [11:0] exp_vec(input int g);
      logic [3:1] h;
      logic [3:1] r;
      logic       o0, o1;
      h = '0;
      r = '0;
      for (int c = 0; c < 2; c++)
         for (int x = 1; x <= 3; x++)
            if (m_src[g][c] == x) begin
               if (m_ph[g][c] == M_SERVICE) h[x] = 1'b1;
               if (m_ph[g][c] == M_RELEASE) r[x] = 1'b1;
            end
      o0 = (m_ph[g][0] == M_OFFER);
      o1 = (m_ph[g][1] == M_OFFER);
      return {o0, o0 ? 2'(m_src[g][0]) : 2'd0, o1, o1 ? 2'(m_src[g][1]) : 2'd0, h, r};
   endfunction

   function automatic logic [11:0] act_vec(input int g);
      if (g == 0) return {v0a, id0a, v1a, id1a, hnda, rta};
      return {v0b, id0b, v1b, id1b, hndb, rtb};
   endfunction

   // Every clock: advance the model on the edge, compare both DUTs just after it.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_advance();
         #1;
         chk($sformatf("model_a@%0d", m_cyc), 32'(act_vec(0)), 32'(exp_vec(0)));
         chk($sformatf("model_b@%0d", m_cyc), 32'(act_vec(1)), 32'(exp_vec(1)));
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flag  = '0;
      avail = '0;
      ack   = '0;
      reti  = '0;
      model_reset();
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int         n;
      int         w;
      logic [3:1] rt_seen;
      logic [7:0] seq;
      checks   = 0;
      failures = 0;
      rst_n = 1'b0;
      flag  = '0;
      avail = '0;
      ack   = '0;
      reti  = '0;
      model_reset();
      #1;
      chk("reset_outputs", 32'({act_vec(0), act_vec(1)}), 32'd0);
      step(2);

      // Single source through offer, service, release, then guarded redispatch.
      do_reset();
      flag  = 3'b010;
      avail = 2'b11;
      step(1);
      chk("t1_offer_c0_id2", 32'({v0a, id0a, v1a}), 32'(4'b1100));
      step(2);
      ack = 2'b01;
      step(1);
      ack = 2'b00;
      chk("t1_handling", 32'({hnda, v0a}), 32'(4'b0100));
      step(6);
      reti = 2'b01;
      step(1);
      reti = 2'b00;
      chk("t1_reti_pulse", 32'({rta, hnda}), 32'(6'b010000));
      step(1);
      chk("t1_reti_once", 32'({rta, v0a, v1a}), 32'd0);
      step(1);
      chk("t1_guard_no_offer", 32'({v0a, v1a}), 32'd0);
      step(1);
      chk("t1_reoffer", 32'({v0a, id0a, v1a}), 32'(4'b1100));

      // Three sources, two CPUs: fixed priority split, third waits, dual RETI.
      do_reset();
      flag  = 3'b111;
      avail = 2'b11;
      step(1);
      chk("t2_split_offer", 32'({v0a, id0a, v1a, id1a}), 32'(6'b101110));
      ack = 2'b11;
      step(1);
      ack = 2'b00;
      chk("t2_both_service", 32'({hnda, v0a, v1a}), 32'(5'b01100));
      reti = 2'b01;
      step(1);
      reti = 2'b00;
      chk("t2_reti_src1", 32'(rta), 32'(3'b001));
      step(1);
      chk("t2_select_cycle", 32'(v0a), 32'd0);
      step(1);
      chk("t2_src3_offer", 32'({v0a, id0a}), 32'(3'b111));
      ack = 2'b01;
      step(1);
      ack = 2'b00;
      chk("t2_service_2_3", 32'(hnda), 32'(3'b110));
      reti = 2'b11;
      flag = 3'b000;
      step(1);
      reti = 2'b00;
      chk("t2_dual_reti", 32'(rta), 32'(3'b110));
      step(3);

      // Unacked offer is withdrawn after ACK_TIMEOUT cycles and re-offered.
      do_reset();
      flag  = 3'b100;
      avail = 2'b01;
      step(1);
      n = 0;
      rt_seen = '0;
      for (int i = 0; i < ACK_T; i++) begin
         if (v0a && id0a == 2'd3) n++;
         rt_seen = rt_seen | rta | rtb;
         step(1);
      end
      chk("t3_valid_cycles", 32'(n), 32'(ACK_T));
      chk("t3_withdrawn", 32'(v0a), 32'd0);
      step(1);
      chk("t3_reoffer", 32'({v0a, id0a}), 32'(3'b111));
      chk("t3_no_reti", 32'(rt_seen), 32'd0);

      // Rotating priority: sources 1 and 3, one CPU.
      do_reset();
      flag  = 3'b101;
      avail = 2'b01;
      seq   = '0;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (!v0b && w < 10) begin
            step(1);
            w++;
         end
         if (!v0b) begin
            chk("t5_offer_wait", 32'(v0b), 32'd1);
            break;
         end
         seq = {seq[5:0], id0b};
         ack = 2'b01;
         step(1);
         ack = 2'b00;
         reti = 2'b01;
         step(1);
         reti = 2'b00;
      end
      chk("t5_rr_sequence", 32'(seq), 32'(8'b01110111));

      // Reset during service: outputs clear at once, fresh offer afterwards.
      do_reset();
      flag  = 3'b001;
      avail = 2'b01;
      step(1);
      ack = 2'b01;
      step(1);
      ack = 2'b00;
      chk("t6_in_service", 32'(hnda), 32'(3'b001));
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_async_clear", 32'({act_vec(0), act_vec(1)}), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(1);
      chk("t6_fresh_offer", 32'({v0a, id0a, rta}), 32'(6'b101000));
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
